// File: rtl/alu4_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// Each grant runs IDLE -> EXEC -> RESP and holds the response until the consumer takes it.
module alu4_arbiter #(
  parameter int ADDER_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*ADDER_WIDTH-1:0]   req_a,
  input  logic [2*ADDER_WIDTH-1:0]   req_b,
  input  logic [1:0]                 req_m,
  input  logic [3:0]                 req_op,
  input  logic [1:0]                 req_cin,
  output logic [ADDER_WIDTH-1:0]     alu_a,
  output logic [ADDER_WIDTH-1:0]     alu_b,
  output logic                       alu_m,
  output logic [1:0]                 alu_op,
  output logic                       alu_cin,
  input  logic [ADDER_WIDTH-1:0]     alu_sum,
  input  logic                       alu_cout,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [ADDER_WIDTH-1:0]     rsp_sum,
  output logic                       rsp_cout,
  input  logic                       rsp_ready
);

  localparam int W = ADDER_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic [W-1:0]     r_alu_a;
  logic [W-1:0]     r_alu_b;
  logic             r_alu_m;
  logic [1:0]       r_alu_op;
  logic             r_alu_cin;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [W-1:0]     r_rsp_sum;
  logic             r_rsp_cout;

  logic             w_grant_id;
  logic             w_grant_en;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic             w_sel_m;
  logic [1:0]       w_sel_op;
  logic             w_sel_cin;
  logic             w_arith_hi;
  logic [W-1:0]     w_sum_masked;
  logic             w_cout_masked;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    w_grant_id = 1'b0;
    case (req_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = ~r_last_grant;
      default: w_grant_id = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_grant_en = 1'b0;
    req_ready  = '0;
    case (r_state)
      IDLE: begin
        if (rst_n && (req_valid != 2'b00)) begin
          w_grant_en = 1'b1;
          req_ready  = w_grant_id ? 2'b10 : 2'b01;
          w_next     = EXEC;
        end
      end
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sel_a   = w_grant_id ? req_a[2*W-1:W] : req_a[W-1:0];
    w_sel_b   = w_grant_id ? req_b[2*W-1:W] : req_b[W-1:0];
    w_sel_m   = w_grant_id ? req_m[1]       : req_m[0];
    w_sel_op  = w_grant_id ? req_op[3:2]    : req_op[1:0];
    w_sel_cin = w_grant_id ? req_cin[1]     : req_cin[0];
  end

  // Arithmetic ops 1x produce a zero result; carry is only meaningful for add/sub.
  always_comb begin
    w_arith_hi    = ~r_alu_m & r_alu_op[1];
    w_sum_masked  = w_arith_hi ? '0 : alu_sum;
    w_cout_masked = ~r_alu_m & ~r_alu_op[1] & alu_cout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_m      <= 1'b0;
      r_alu_op     <= '0;
      r_alu_cin    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_sum    <= '0;
      r_rsp_cout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_en) begin
        r_last_grant <= w_grant_id;
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_alu_m      <= w_sel_m;
        r_alu_op     <= w_sel_op;
        r_alu_cin    <= w_sel_cin;
      end
      if (r_state == EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_last_grant;
        r_rsp_sum   <= w_sum_masked;
        r_rsp_cout  <= w_cout_masked;
      end
      if ((r_state == RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_m     = r_alu_m;
  assign alu_op    = r_alu_op;
  assign alu_cin   = r_alu_cin;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_alu4_arbiter.sv
// Scoreboard bench for alu4_arbiter with a behavioural external ALU.
module tb_alu4_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_m;
  logic [3:0] req_op;
  logic [1:0] req_cin;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_m;
  logic [1:0] alu_op;
  logic       alu_cin;
  logic [3:0] alu_sum;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_id;
  logic [3:0] rsp_sum;
  logic       rsp_cout;
  logic       rsp_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       id;
    logic [3:0] sum;
    logic       cout;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu4_arbiter #(.ADDER_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_m(req_m), .req_op(req_op), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_ready(rsp_ready)
  );

  // External ALU: ops whose carry or sum the arbiter must mask return junk on purpose.
  always_comb begin
    alu_sum  = '0;
    alu_cout = 1'b0;
    if (!alu_m) begin
      case (alu_op)
        2'b00:   {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        2'b01:   {alu_cout, alu_sum} = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
        default: {alu_cout, alu_sum} = {1'b1, alu_a ^ alu_b ^ 4'h5};
      endcase
    end else begin
      alu_cout = 1'b1;
      case (alu_op)
        2'b00:   alu_sum = alu_a & alu_b;
        2'b01:   alu_sum = alu_a | alu_b;
        2'b10:   alu_sum = alu_a ^ alu_b;
        default: alu_sum = alu_b;
      endcase
    end
  end

  function automatic exp_t exp_calc(logic id, logic [3:0] a, logic [3:0] b,
                                    logic m, logic [1:0] op, logic cin);
    exp_t e;
    int   s;
    e.id = id; e.sum = 4'h0; e.cout = 1'b0;
    if (!m) begin
      if (op == 2'd0) begin
        s = int'(a) + int'(b) + int'(cin);
        e.sum = 4'(s); e.cout = (s > 15);
      end else if (op == 2'd1) begin
        s = int'(a) - int'(b) - int'(cin);
        e.sum = 4'(s); e.cout = (s < 0);
      end
    end else begin
      case (op)
        2'd0:    e.sum = a & b;
        2'd1:    e.sum = a | b;
        2'd2:    e.sum = a ^ b;
        default: e.sum = b;
      endcase
    end
    return e;
  endfunction

  task automatic set_req(int idx, logic [3:0] a, logic [3:0] b,
                         logic m, logic [1:0] op, logic cin);
    req_a[idx*4 +: 4]  = a;
    req_b[idx*4 +: 4]  = b;
    req_m[idx]         = m;
    req_op[idx*2 +: 2] = op;
    req_cin[idx]       = cin;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_m = '0; req_op = '0; req_cin = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_id, rsp_sum, rsp_cout} !== 6'b0) begin failures++; $display("FAIL reset_rsp: got %b want 0", {rsp_id, rsp_sum, rsp_cout}); end
    checks++; if ({alu_a, alu_b, alu_m, alu_op, alu_cin} !== 12'b0) begin failures++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_m, alu_op, alu_cin}); end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 2'b00;
  endtask

  task automatic test_add();
    exp_t e;
    step();
    set_req(0, 4'h9, 4'h8, 1'b0, 2'b00, 1'b0); req_valid = 2'b01;
    q.push_back(exp_calc(1'b0, 4'h9, 4'h8, 1'b0, 2'b00, 1'b0));
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL add_grant: got %b want 01", req_ready); end
    step(); req_valid = 2'b00;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid: got %b want 0", rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_m, alu_op, alu_cin} !== {4'h9, 4'h8, 4'b0}) begin failures++; $display("FAIL add_alu_regs: got %h want 980", {alu_a, alu_b, alu_m, alu_op, alu_cin}); end
    step(); @(negedge clk);
    e = q.pop_front();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL add_valid_t2: got %b want 1", rsp_valid); end
    checks++; if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout}) begin failures++; $display("FAIL add_rsp: got %b want %b", {rsp_id, rsp_sum, rsp_cout}, {e.id, e.sum, e.cout}); end
    step(); @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_valid_clear: got %b want 0", rsp_valid); end
    checks++; if (alu_a !== 4'h9) begin failures++; $display("FAIL add_alu_hold: got %h want 9", alu_a); end
  endtask

  task automatic test_ops();
    exp_t e;
    logic [3:0] ta [4] = '{4'h3, 4'h7, 4'hC, 4'hC};
    logic [3:0] tb [4] = '{4'h5, 4'h3, 4'hA, 4'hA};
    logic       tm [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] to [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
    logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int         ti [4] = '{1, 0, 0, 0};
    for (int n = 0; n < 4; n++) begin
      step();
      set_req(ti[n], ta[n], tb[n], tm[n], to[n], tc[n]);
      req_valid = (ti[n] == 1) ? 2'b10 : 2'b01;
      q.push_back(exp_calc(ti[n] == 1, ta[n], tb[n], tm[n], to[n], tc[n]));
      @(negedge clk);
      checks++; if (req_ready !== req_valid) begin failures++; $display("FAIL ops_grant[%0d]: got %b want %b", n, req_ready, req_valid); end
      step(); req_valid = 2'b00;
      step(); @(negedge clk);
      e = q.pop_front();
      checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, e.id, e.sum, e.cout}) begin failures++; $display("FAIL ops_rsp[%0d]: got %b want %b", n, {rsp_valid, rsp_id, rsp_sum, rsp_cout}, {1'b1, e.id, e.sum, e.cout}); end
      step();
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [1:0] want;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    set_req(0, 4'h2, 4'h3, 1'b0, 2'b00, 1'b1);
    set_req(1, 4'hF, 4'h1, 1'b0, 2'b00, 1'b0);
    for (int g = 0; g < 4; g++)
      q.push_back((g % 2 == 0) ? exp_calc(1'b0, 4'h2, 4'h3, 1'b0, 2'b00, 1'b1)
                               : exp_calc(1'b1, 4'hF, 4'h1, 1'b0, 2'b00, 1'b0));
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      @(negedge clk);
      want = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (req_ready !== want) begin failures++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, want); end
      if (k % 3 == 2) begin
        e = q.pop_front();
        checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, e.id, e.sum, e.cout}) begin failures++; $display("FAIL rr_rsp[%0d]: got %b want %b", k, {rsp_valid, rsp_id, rsp_sum, rsp_cout}, {1'b1, e.id, e.sum, e.cout}); end
      end
    end
    step(); req_valid = 2'b00;
    step(); step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    step();
    rsp_ready = 1'b0;
    set_req(0, 4'h5, 4'h6, 1'b1, 2'b01, 1'b0);
    set_req(1, 4'h4, 4'h4, 1'b0, 2'b01, 1'b1);
    req_valid = 2'b11;
    q.push_back(exp_calc(1'b0, 4'h5, 4'h6, 1'b1, 2'b01, 1'b0));
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant0: got %b want 01", req_ready); end
    step(); step();
    e = q.pop_front();
    for (int k = 2; k <= 6; k++) begin
      if (k > 2) step();
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready} !== {1'b1, e.id, e.sum, e.cout, 2'b00}) begin failures++; $display("FAIL bp_hold[%0d]: got %b want %b", k, {rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready}, {1'b1, e.id, e.sum, e.cout, 2'b00}); end
    end
    step(); rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 3'b100) begin failures++; $display("FAIL bp_release: got %b want 100", {rsp_valid, req_ready}); end
    step();
    q.push_back(exp_calc(1'b1, 4'h4, 4'h4, 1'b0, 2'b01, 1'b1));
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 3'b010) begin failures++; $display("FAIL bp_next_grant: got %b want 010", {rsp_valid, req_ready}); end
    step(); req_valid = 2'b00;
    step(); @(negedge clk);
    e = q.pop_front();
    checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, e.id, e.sum, e.cout}) begin failures++; $display("FAIL bp_rsp1: got %b want %b", {rsp_valid, rsp_id, rsp_sum, rsp_cout}, {1'b1, e.id, e.sum, e.cout}); end
    step();
  endtask

  task automatic test_reset_midop();
    exp_t e;
    step();
    set_req(1, 4'h1, 4'h1, 1'b0, 2'b00, 1'b0);
    req_valid = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rst_mid_grant: got %b want 10", req_ready); end
    step();
    rst_n = 1'b0; req_valid = 2'b11;
    set_req(0, 4'h8, 4'h8, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_mid_exec_ready: got %b want 00", req_ready); end
    step(); rst_n = 1'b1;
    q.push_back(exp_calc(1'b0, 4'h8, 4'h8, 1'b0, 2'b00, 1'b0));
    @(negedge clk);
    checks++; if ({rsp_valid, alu_a, req_ready} !== 7'b0_0000_01) begin failures++; $display("FAIL rst_mid_idle: got %b want 0000001", {rsp_valid, alu_a, req_ready}); end
    step(); req_valid = 2'b00;
    step(); @(negedge clk);
    e = q.pop_front();
    checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, e.id, e.sum, e.cout}) begin failures++; $display("FAIL rst_mid_rsp: got %b want %b", {rsp_valid, rsp_id, rsp_sum, rsp_cout}, {1'b1, e.id, e.sum, e.cout}); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_round_robin();
    test_back_to_back();
    test_reset_midop();
    checks++; if (q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d want 0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu4_arbiter.md
ALU4_ARBITER -- requirements
Module: alu4_arbiter

Interface
REQ-001 The parameter list SHALL be: ADDER_WIDTH, default 4, operand/result width W.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit; reset is synchronous and active-low.
REQ-004 Port req_valid SHALL be: input, 2 bits, bit n = requester n has an operation pending.
REQ-005 Port req_ready SHALL be: output, 2 bits, one-hot accept strobe to the granted requester.
REQ-006 Port req_a SHALL be: input, 2W bits, {req1_a, req0_a}.
REQ-007 Port req_b SHALL be: input, 2W bits, {req1_b, req0_b}.
REQ-008 Port req_m SHALL be: input, 2 bits; 0 = arithmetic, 1 = logic.
REQ-009 Port req_op SHALL be: input, 4 bits, {req1_op, req0_op}.
REQ-010 Port req_cin SHALL be: input, 2 bits, per-requester carry/borrow in.
REQ-011 Ports alu_a and alu_b SHALL be: outputs, W bits each, registered operands to the shared ALU.
REQ-012 Ports alu_m, alu_op and alu_cin SHALL be: outputs of 1, 2 and 1 bits, registered ALU controls.
REQ-013 Ports alu_sum and alu_cout SHALL be: inputs of W and 1 bits, combinational ALU result.
REQ-014 Port rsp_valid SHALL be: output, 1 bit, result available.
REQ-015 Port rsp_id SHALL be: output, 1 bit, index of the requester that owns the result.
REQ-016 Port rsp_sum SHALL be: output, W bits, result value.
REQ-017 Port rsp_cout SHALL be: output, 1 bit, carry/borrow out of the result.
REQ-018 Port rsp_ready SHALL be: input, 1 bit, consumer accepts the result.

Function
REQ-019 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-020 In IDLE with req_valid != 0, the block SHALL grant one requester, assert req_ready[g] combinationally for that cycle only, register that requester's a/b/m/op/cin onto alu_*, and go to EXEC.
REQ-021 In IDLE with req_valid == 0, the block SHALL assert no req_ready and remain in IDLE.
REQ-022 When one requester is valid, that requester SHALL be granted.
REQ-023 When both requesters are valid, the requester not granted last SHALL be granted (round-robin); last_grant SHALL update on every grant.
REQ-024 In EXEC, the block SHALL hold alu_* stable, register alu_sum into rsp_sum and the masked cout into rsp_cout, register the grant index into rsp_id, set rsp_valid, and go to RESP.
REQ-025 Masked cout SHALL equal alu_cout when m=0 and op[1]=0, and SHALL be 0 otherwise (logic ops, and arithmetic op 1x).
REQ-026 For m=0 with op=1x, rsp_sum SHALL be 0.
REQ-027 In RESP, rsp_valid/rsp_id/rsp_sum/rsp_cout SHALL hold stable until rsp_ready=1.
REQ-028 On rsp_ready=1 in RESP, the block SHALL clear rsp_valid and go to IDLE; no new request is accepted in that same cycle.
REQ-029 Latency SHALL be: accept in cycle T, rsp_valid=1 in cycle T+2; minimum issue interval 3 cycles.
REQ-030 req_ready SHALL be 0 in EXEC and RESP, regardless of req_valid.
REQ-031 rsp_ready while not in RESP SHALL be ignored.
REQ-032 alu_* SHALL retain their last values in RESP and IDLE until the next grant.

Reset
REQ-033 With rst_n=0 at a rising edge, the block SHALL go to IDLE and clear rsp_valid, rsp_id, rsp_sum, rsp_cout and alu_* to 0, with req_ready=0.
REQ-034 Reset SHALL set last_grant=1, so requester 0 wins the first tie.
REQ-035 Reset asserted in EXEC or RESP SHALL abort the operation with no response issued; a request pending at release SHALL be re-arbitrated from IDLE.

Verification
REQ-036 Scenario: req0 a=9, b=8, m=0, op=00, cin=0 -> req_ready=01 at T; rsp_valid at T+2 with id 0, sum 1, cout 1.
REQ-037 Scenario: req1 a=3, b=5, m=0, op=01, cin=0 -> rsp id 1, sum 4'hE, cout 1.
REQ-038 Scenario: both valid continuously after reset, with rsp_ready tied high -> grant order 0,1,0,1, one grant per 3 cycles.
REQ-039 Scenario: req0 m=1, op=00, a=C, b=A; then m=1, op=11 -> sum 8, cout 0; then sum A, cout 0.
REQ-040 Scenario: rsp_ready held low 5 cycles in RESP, with req_valid=11 -> rsp_* stable and req_ready=00 throughout; IDLE follows the rsp_ready cycle.
REQ-041 Scenario: rst_n=0 during EXEC -> next cycle IDLE, rsp_valid=0, and requester 0 wins the next tie.
